// File: rtl/sdram_init.sv
// SDRAM power-up sequencer: wait, PRECHARGE ALL, AUTO REFRESH burst,
// LOAD MODE, then a sticky done flag that releases the command bus.
module sdram_init #(
  parameter int ADDR_WIDTH    = 13,
  parameter int T_POWERUP_CYC = 10000,
  parameter int T_RP_CYC      = 2,
  parameter int T_RFC_CYC     = 7,
  parameter int T_MRD_CYC     = 2,
  parameter int NUM_AREF      = 8,
  parameter logic [ADDR_WIDTH-1:0] MODE_REG = 'h0032
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  output logic                  o_cke,
  output logic [3:0]            o_cmd,
  output logic [1:0]            o_ba,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_init_done
);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  localparam logic [15:0] PWR  = 16'(T_POWERUP_CYC);
  localparam logic [15:0] TRP  = 16'(T_RP_CYC);
  localparam logic [15:0] TRFC = 16'(T_RFC_CYC);
  localparam logic [15:0] TMRD = 16'(T_MRD_CYC);
  localparam logic [3:0]  NREF = 4'(NUM_AREF);

  if (T_POWERUP_CYC < 1 || T_POWERUP_CYC > 65535 ||
      T_RP_CYC < 1 || T_RP_CYC > 255 ||
      T_RFC_CYC < 1 || T_RFC_CYC > 255 ||
      T_MRD_CYC < 1 || T_MRD_CYC > 255 ||
      NUM_AREF < 1 || NUM_AREF > 15 ||
      ADDR_WIDTH < 11) begin : g_bad_param
    $error("sdram_init: parameter out of range");
  end

  typedef enum logic [2:0] {
    S_WAIT, S_PRE, S_TRP, S_AREF,
    S_TRFC, S_MRS, S_TMRD, S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           cnt_q, cnt_d;
  logic [3:0]            ref_q, ref_d;
  logic                  cke_q, cke_d;
  logic [3:0]            cmd_q, cmd_d;
  logic [1:0]            ba_q, ba_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  done_q, done_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_WAIT;
      cnt_q   <= '0;
      ref_q   <= '0;
      cke_q   <= 1'b0;
      cmd_q   <= CMD_NOP;
      ba_q    <= '0;
      addr_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
      cke_q   <= cke_d;
      cmd_q   <= cmd_d;
      ba_q    <= ba_d;
      addr_q  <= addr_d;
      done_q  <= done_d;
    end
  end

  // cnt_q counts cycles since the last command; a command issues
  // on the edge where it equals the required spacing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ref_d   = ref_q;
    cke_d   = 1'b1;
    cmd_d   = CMD_NOP;
    ba_d    = '0;
    addr_d  = '0;
    done_d  = done_q;
    unique case (state_q)
      S_WAIT: begin
        if (cnt_q == PWR) begin
          state_d    = S_PRE;
          cnt_d      = 16'd1;
          cmd_d      = CMD_PRE;
          addr_d[10] = 1'b1;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_PRE, S_TRP: begin
        if (cnt_q == TRP) begin
          state_d = S_AREF;
          cnt_d   = 16'd1;
          ref_d   = ref_q + 4'd1;
          cmd_d   = CMD_AREF;
        end else begin
          state_d = S_TRP;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      S_AREF, S_TRFC: begin
        if (cnt_q == TRFC) begin
          cnt_d = 16'd1;
          if (ref_q == NREF) begin
            state_d = S_MRS;
            cmd_d   = CMD_MRS;
            addr_d  = MODE_REG;
          end else begin
            state_d = S_AREF;
            ref_d   = ref_q + 4'd1;
            cmd_d   = CMD_AREF;
          end
        end else begin
          state_d = S_TRFC;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      S_MRS, S_TMRD: begin
        if (cnt_q == TMRD) begin
          state_d = S_DONE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          state_d = S_TMRD;
          cnt_d   = cnt_q + 16'd1;
        end
      end
      S_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        state_d = S_WAIT;
        cnt_d   = '0;
        ref_d   = '0;
      end
    endcase
  end

  assign o_cke       = cke_q;
  assign o_cmd       = cmd_q;
  assign o_ba        = ba_q;
  assign o_addr      = addr_q;
  assign o_init_done = done_q;

endmodule

// File: tb/tb_sdram_init.sv
// Directed bench for sdram_init: default timing, fast back-to-back
// timing, async reset while done and mid-sequence restart.
module tb_sdram_init;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] MRS  = 4'b0000;

  logic        clk;
  logic        rst_n;
  logic        cke, done;
  logic [3:0]  cmd;
  logic [1:0]  ba;
  logic [12:0] addr;
  logic        f_cke, f_done;
  logic [3:0]  f_cmd;
  logic [1:0]  f_ba;
  logic [12:0] f_addr;

  sdram_init dut (
    .i_clk(clk), .i_rst_n(rst_n), .o_cke(cke), .o_cmd(cmd),
    .o_ba(ba), .o_addr(addr), .o_init_done(done)
  );

  sdram_init #(
    .T_POWERUP_CYC(4), .T_RP_CYC(1), .T_RFC_CYC(1),
    .T_MRD_CYC(1), .NUM_AREF(2)
  ) dut_f (
    .i_clk(clk), .i_rst_n(rst_n), .o_cke(f_cke), .o_cmd(f_cmd),
    .o_ba(f_ba), .o_addr(f_addr), .o_init_done(f_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int pre_cyc, pre_addr, aref_n, mrs_cyc, mrs_addr, mrs_ba;
  int done_cyc, done_drop, cke_bad, nop_bad, illegal, post_cmd;
  int aref_cyc [16];
  logic [3:0] f_cmd_log [12];
  logic       f_done_log [12];
  logic [12:0] f_addr_log [12];

  task automatic run_seq(input int ncyc);
    pre_cyc = -1; pre_addr = 0; aref_n = 0; mrs_cyc = -1;
    mrs_addr = 0; mrs_ba = 0; done_cyc = -1; done_drop = 0;
    cke_bad = 0; nop_bad = 0; illegal = 0; post_cmd = 0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      if (c < 12) begin
        f_cmd_log[c]  = f_cmd;
        f_done_log[c] = f_done;
        f_addr_log[c] = f_addr;
      end
      if (cke !== 1'b1) cke_bad++;
      if (cmd == NOP && (addr != 0 || ba != 0)) nop_bad++;
      case (cmd)
        NOP: ;
        PRE: begin pre_cyc = c; pre_addr = int'(addr); end
        AREF: begin
          if (aref_n < 16) aref_cyc[aref_n] = c;
          aref_n++;
        end
        MRS: begin
          mrs_cyc = c; mrs_addr = int'(addr); mrs_ba = int'(ba);
        end
        default: illegal++;
      endcase
      if (done === 1'b1 && done_cyc < 0) done_cyc = c;
      if (done_cyc >= 0 && done !== 1'b1) done_drop++;
      if (done_cyc >= 0 && cmd != NOP) post_cmd++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    #12;
    check("rst_cke", 32'(cke), 0);
    check("rst_cmd", 32'(cmd), 32'(NOP));
    check("rst_addr", 32'(addr), 0);
    check("rst_ba", 32'(ba), 0);
    check("rst_done", 32'(done), 0);

    @(negedge clk);
    rst_n = 1'b1;
    run_seq(11100);

    check("pre_cyc", pre_cyc, 10000);
    check("pre_addr", pre_addr, 32'h0400);
    check("aref_n", aref_n, 8);
    for (int k = 0; k < 8; k++)
      check($sformatf("aref%0d_cyc", k), aref_cyc[k], 10002 + 7 * k);
    check("mrs_cyc", mrs_cyc, 10058);
    check("mrs_addr", mrs_addr, 32'h0032);
    check("mrs_ba", mrs_ba, 0);
    check("done_cyc", done_cyc, 10060);
    check("done_drop", done_drop, 0);
    check("cke_bad", cke_bad, 0);
    check("nop_addr_bad", nop_bad, 0);
    check("illegal_cmd", illegal, 0);
    check("post_done_cmd", post_cmd, 0);

    for (int c = 0; c < 4; c++)
      check($sformatf("fast_nop%0d", c), 32'(f_cmd_log[c]), 32'(NOP));
    check("fast_pre", 32'(f_cmd_log[4]), 32'(PRE));
    check("fast_pre_addr", 32'(f_addr_log[4]), 32'h0400);
    check("fast_aref0", 32'(f_cmd_log[5]), 32'(AREF));
    check("fast_aref1", 32'(f_cmd_log[6]), 32'(AREF));
    check("fast_mrs", 32'(f_cmd_log[7]), 32'(MRS));
    check("fast_mrs_addr", 32'(f_addr_log[7]), 32'h0032);
    check("fast_done7", 32'(f_done_log[7]), 0);
    check("fast_done8", 32'(f_done_log[8]), 1);
    check("fast_cmd8", 32'(f_cmd_log[8]), 32'(NOP));

    // async reset between edges while done is high
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_done", 32'(done), 0);
    check("async_cke", 32'(cke), 0);
    check("async_cmd", 32'(cmd), 32'(NOP));

    @(negedge clk);
    rst_n = 1'b1;
    run_seq(10021);
    rst_n = 1'b0;
    #1;
    check("mid_cke", 32'(cke), 0);
    check("mid_cmd", 32'(cmd), 32'(NOP));
    check("mid_addr", 32'(addr), 0);
    check("mid_done", 32'(done), 0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_seq(10070);
    check("re_pre_cyc", pre_cyc, 10000);
    check("re_aref_n", aref_n, 8);
    check("re_mrs_cyc", mrs_cyc, 10058);
    check("re_done_cyc", done_cyc, 10060);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
